pick_mover: RTL and testbench

Parametrised two-axis cursor/pick position controller for the playfield overlay. Accepts per-frame direction commands, moves the pick by a configurable step, wraps or clamps independently per axis at programmable bounds, and optionally accelerates after a sustained hold. Its position outputs feed the sprite renderer and hit-test logic directly.

---
 rtl/pick_pkg.sv | 20 ++
 rtl/pick_axis.sv | 61 ++++++
 rtl/pick_mover.sv | 167 ++++++++++++++++
 tb/tb_pick_mover.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pick_pkg.sv
// Shared types and constants for the pick position controller.
// The speed state and direction codes are used by both the top and the per-axis stepper.
package pick_pkg;

  typedef enum logic [1:0] {
    SPD_IDLE = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } speed_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_NEG  = 2'b01;
  localparam logic [1:0] DIR_POS  = 2'b10;

  // Code 11 is meaningless on the command bus and is treated as "no movement".
  function automatic logic [1:0] norm_dir(input logic [1:0] d);
    return (d == 2'b11) ? DIR_NONE : d;
  endfunction

endpackage

// File: rtl/pick_axis.sv
// One axis of the pick: applies a step in the requested direction and resolves
// boundary crossings by wrapping or clamping. Purely combinational; the caller
// registers the result.
module pick_axis
  import pick_pkg::*;
#(
  parameter int W    = 10,
  parameter int MIN  = 0,
  parameter int MAX  = 639,
  parameter bit WRAP = 1'b1
) (
  input  logic [W-1:0] pos,
  input  logic [1:0]   dir,
  input  logic [W-1:0] step,
  output logic [W-1:0] pos_next,
  output logic         hit
);

  localparam logic [W:0] MIN_E = (W+1)'(MIN);
  localparam logic [W:0] MAX_E = (W+1)'(MAX);

  // One extra bit keeps MIN+step and pos+step from overflowing.
  logic [W:0] pos_e;
  logic [W:0] step_e;
  logic [W:0] lo_lim;
  logic [W:0] hi_sum;

  assign pos_e  = {1'b0, pos};
  assign step_e = {1'b0, step};
  assign lo_lim = MIN_E + step_e;
  assign hi_sum = pos_e + step_e;

  // Step the axis; the boundary branch flags hit even when a clamp leaves pos unchanged.
  always_comb begin
    pos_next = pos;
    hit      = 1'b0;
    case (dir)
      DIR_NEG: begin
        if (pos_e < lo_lim) begin
          hit      = 1'b1;
          pos_next = WRAP ? MAX_E[W-1:0] : MIN_E[W-1:0];
        end else begin
          pos_next = pos - step;
        end
      end
      DIR_POS: begin
        if (hi_sum > MAX_E) begin
          hit      = 1'b1;
          pos_next = WRAP ? MIN_E[W-1:0] : MAX_E[W-1:0];
        end else begin
          pos_next = pos + step;
        end
      end
      default: begin
        pos_next = pos;
        hit      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pick_mover.sv
// Two-axis pick position controller, one update per video frame.
// Optional acceleration after a sustained hold is enabled by defining PICK_ACCEL_EN;
// without it the pick only ever moves at STEP_SLOW and speed never reads FAST.
module pick_mover
  import pick_pkg::*;
#(
  parameter int W           = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 479,
  parameter int X_HOME      = 100,
  parameter int Y_HOME      = 32,
  parameter int STEP_SLOW   = 1,
  parameter int STEP_FAST   = 2,
  parameter int HOLD_FRAMES = 8,
  parameter bit X_WRAP      = 1'b1,
  parameter bit Y_WRAP      = 1'b1
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  input  logic         cmd_valid,
  input  logic [1:0]   dir_x,
  input  logic [1:0]   dir_y,
  input  logic         home,
  input  logic         freeze,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [1:0]   speed,
  output logic         moving,
  output logic         wrapped
);

  localparam logic [W-1:0] X_HOME_W = W'(X_HOME);
  localparam logic [W-1:0] Y_HOME_W = W'(Y_HOME);
  localparam logic [W-1:0] STEP_S   = W'(STEP_SLOW);
  localparam int           SPAN_MIN = ((X_MAX - X_MIN) < (Y_MAX - Y_MIN)) ?
                                      (X_MAX - X_MIN) : (Y_MAX - Y_MIN);

  // Reject parameter sets that would break the bounds arithmetic.
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
    $error("pick_mover: HOLD_FRAMES must be in 1..255");
  end
  if (X_HOME < X_MIN || X_HOME > X_MAX || Y_HOME < Y_MIN || Y_HOME > Y_MAX) begin : g_bad_home
    $error("pick_mover: home position outside bounds");
  end
  if (STEP_SLOW > SPAN_MIN || STEP_FAST > SPAN_MIN) begin : g_bad_step
    $error("pick_mover: step larger than the smaller axis span");
  end

  speed_t       state;
  speed_t       state_next;
  logic [3:0]   vec;
  logic [W-1:0] step;
  logic [W-1:0] nx;
  logic [W-1:0] ny;
  logic         hx;
  logic         hy;

  assign vec   = cmd_valid ? {norm_dir(dir_x), norm_dir(dir_y)} : 4'b0000;
  assign speed = state;

`ifdef PICK_ACCEL_EN
  localparam logic [W-1:0] STEP_F = W'(STEP_FAST);
  localparam logic [7:0]   HOLD   = 8'(HOLD_FRAMES);

  logic [7:0] count;
  logic [7:0] count_next;
  logic [3:0] prev_vec;
  logic [3:0] prev_next;

  assign step = (state == SPD_FAST) ? STEP_F : STEP_S;

  // Hold counter and last nonzero vector follow the same home/freeze priority as the position.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      count    <= 8'd0;
      prev_vec <= 4'b0000;
    end else if (home) begin
      count    <= 8'd0;
    end else if (!freeze) begin
      count    <= count_next;
      prev_vec <= prev_next;
    end
  end

  // Next speed state: a repeated vector counts toward FAST, any change restarts at SLOW.
  always_comb begin
    state_next = state;
    count_next = count;
    prev_next  = prev_vec;
    if (vec == 4'b0000) begin
      state_next = SPD_IDLE;
      count_next = 8'd0;
    end else begin
      if (state != SPD_IDLE && vec == prev_vec) begin
        count_next = (count >= HOLD) ? HOLD : count + 8'd1;
      end else begin
        count_next = 8'd1;
      end
      prev_next  = vec;
      state_next = (count_next >= HOLD) ? SPD_FAST : SPD_SLOW;
    end
  end
`else
  assign step = STEP_S;

  // Next speed state without acceleration: moving means SLOW, otherwise IDLE.
  always_comb begin
    state_next = state;
    state_next = (vec == 4'b0000) ? SPD_IDLE : SPD_SLOW;
  end
`endif

  pick_axis #(
    .W    (W),
    .MIN  (X_MIN),
    .MAX  (X_MAX),
    .WRAP (X_WRAP)
  ) u_axis_x (
    .pos      (pos_x),
    .dir      (vec[3:2]),
    .step     (step),
    .pos_next (nx),
    .hit      (hx)
  );

  pick_axis #(
    .W    (W),
    .MIN  (Y_MIN),
    .MAX  (Y_MAX),
    .WRAP (Y_WRAP)
  ) u_axis_y (
    .pos      (pos_y),
    .dir      (vec[1:0]),
    .step     (step),
    .pos_next (ny),
    .hit      (hy)
  );

  // State register, position and status flags with reset > home > freeze > command priority.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state   <= SPD_IDLE;
      pos_x   <= X_HOME_W;
      pos_y   <= Y_HOME_W;
      moving  <= 1'b0;
      wrapped <= 1'b0;
    end else if (home) begin
      state   <= SPD_IDLE;
      pos_x   <= X_HOME_W;
      pos_y   <= Y_HOME_W;
      moving  <= (pos_x != X_HOME_W) || (pos_y != Y_HOME_W);
      wrapped <= 1'b0;
    end else if (freeze) begin
      moving  <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      state   <= state_next;
      pos_x   <= nx;
      pos_y   <= ny;
      moving  <= (nx != pos_x) || (ny != pos_y);
      wrapped <= hx | hy;
    end
  end

endmodule

// File: tb/tb_pick_mover.sv
// Self-checking bench for pick_mover. Two instances share the inputs: one wraps on
// both axes, the other clamps. A behavioural model predicts every edge for both and
// queues the expectation; each test pops and compares after the edge.
// Follows PICK_ACCEL_EN the same way the design does.
module tb_pick_mover;
  import pick_pkg::*;

  localparam int W         = 10;
  localparam int X_MIN     = 0;
  localparam int X_MAX     = 639;
  localparam int Y_MIN     = 32;
  localparam int Y_MAX     = 479;
  localparam int X_HOME    = 100;
  localparam int Y_HOME    = 32;
  localparam int STEP_SLOW = 1;
  localparam int STEP_FAST = 2;
  localparam int HOLD      = 8;
`ifdef PICK_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   spd;
    logic         mov;
    logic         wr;
  } obs_t;

  logic         frame_clk = 1'b0;
  logic         Reset_n   = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   dir_x     = 2'b00;
  logic [1:0]   dir_y     = 2'b00;
  logic         home      = 1'b0;
  logic         freeze    = 1'b0;

  logic [W-1:0] pos_x_w, pos_y_w, pos_x_c, pos_y_c;
  logic [1:0]   speed_w, speed_c;
  logic         moving_w, moving_c, wrapped_w, wrapped_c;

  obs_t sb_w[$];
  obs_t sb_c[$];
  int   checks = 0;
  int   errors = 0;

  int         mx[2], my[2], mcnt[2], mspd[2];
  logic [3:0] mprev[2];

  pick_mover #(.X_WRAP(1'b1), .Y_WRAP(1'b1)) dut_wrap (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .cmd_valid (cmd_valid),
    .dir_x (dir_x), .dir_y (dir_y), .home (home), .freeze (freeze),
    .pos_x (pos_x_w), .pos_y (pos_y_w), .speed (speed_w),
    .moving (moving_w), .wrapped (wrapped_w)
  );

  pick_mover #(.X_WRAP(1'b0), .Y_WRAP(1'b0)) dut_clamp (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .cmd_valid (cmd_valid),
    .dir_x (dir_x), .dir_y (dir_y), .home (home), .freeze (freeze),
    .pos_x (pos_x_c), .pos_y (pos_y_c), .speed (speed_c),
    .moving (moving_c), .wrapped (wrapped_c)
  );

  // Frame clock.
  always #5 frame_clk = ~frame_clk;

  function automatic obs_t obs_w();
    return {pos_x_w, pos_y_w, speed_w, moving_w, wrapped_w};
  endfunction

  function automatic obs_t obs_c();
    return {pos_x_c, pos_y_c, speed_c, moving_c, wrapped_c};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("x=%0d y=%0d spd=%0d mov=%0d wr=%0d", o.x, o.y, o.spd, o.mov, o.wr);
  endfunction

  function automatic void axis_model(input int pos, input logic [1:0] d, input int st,
                                     input int lo, input int hi, input bit wrp,
                                     output int np, output bit hit);
    np  = pos;
    hit = 1'b0;
    if (d == 2'b01) begin
      if (pos < lo + st) begin hit = 1'b1; np = wrp ? hi : lo; end
      else np = pos - st;
    end else if (d == 2'b10) begin
      if (pos + st > hi) begin hit = 1'b1; np = wrp ? lo : hi; end
      else np = pos + st;
    end
  endfunction

  task automatic model_edge(input int k, input bit wrp, input logic rn, input logic cv,
                            input logic [1:0] dx, input logic [1:0] dy,
                            input logic hm, input logic fz, output obs_t o);
    logic [1:0] ndx, ndy;
    logic [3:0] v;
    int st, nx, ny;
    bit hx, hy;
    o = '0;
    if (!rn) begin
      mx[k] = X_HOME; my[k] = Y_HOME; mspd[k] = 0; mcnt[k] = 0; mprev[k] = 4'b0;
    end else if (hm) begin
      o.mov = (mx[k] != X_HOME) || (my[k] != Y_HOME);
      mx[k] = X_HOME; my[k] = Y_HOME; mspd[k] = 0; mcnt[k] = 0;
    end else if (!fz) begin
      ndx = (cv && dx != 2'b11) ? dx : 2'b00;
      ndy = (cv && dy != 2'b11) ? dy : 2'b00;
      v   = {ndx, ndy};
      st  = (mspd[k] == 2) ? STEP_FAST : STEP_SLOW;
      axis_model(mx[k], ndx, st, X_MIN, X_MAX, wrp, nx, hx);
      axis_model(my[k], ndy, st, Y_MIN, Y_MAX, wrp, ny, hy);
      o.mov = (nx != mx[k]) || (ny != my[k]);
      o.wr  = hx | hy;
      if (v == 4'b0) begin
        mspd[k] = 0; mcnt[k] = 0;
      end else begin
        if (mspd[k] != 0 && v == mprev[k]) mcnt[k] = (mcnt[k] + 1 > HOLD) ? HOLD : mcnt[k] + 1;
        else mcnt[k] = 1;
        mprev[k] = v;
        mspd[k]  = (ACCEL && mcnt[k] >= HOLD) ? 2 : 1;
      end
      mx[k] = nx; my[k] = ny;
    end
    o.x   = W'(mx[k]);
    o.y   = W'(my[k]);
    o.spd = 2'(mspd[k]);
  endtask

  // Drive one frame's inputs, queue the predicted result for both instances, and step the clock.
  task automatic applyStimulus(input logic rn, input logic cv, input logic [1:0] dx,
                               input logic [1:0] dy, input logic hm, input logic fz);
    obs_t o;
    @(negedge frame_clk);
    Reset_n = rn; cmd_valid = cv; dir_x = dx; dir_y = dy; home = hm; freeze = fz;
    model_edge(0, 1'b1, rn, cv, dx, dy, hm, fz, o);
    sb_w.push_back(o);
    model_edge(1, 1'b0, rn, cv, dx, dy, hm, fz, o);
    sb_c.push_back(o);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t ew, ec;
    for (int i = 0; i < 2; i++) begin
      // First edge holds reset while a command is present; it must be discarded.
      applyStimulus(i != 0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL reset[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL reset[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    void'(sb_w.pop_front()); void'(sb_c.pop_front());
    checks++;
    if (obs_w() !== {10'd100, 10'd32, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_const: got %s want x=100 y=32 spd=0 mov=0 wr=0", fmt(obs_w()));
    end
  endtask

  task automatic test_accel();
    obs_t ew, ec;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL accel[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL accel[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
    end
    checks++;
    if (pos_y_w !== (ACCEL ? 10'd44 : 10'd42)) begin
      errors++; $display("[TB] FAIL accel_pos_y: got %0d want %0d", pos_y_w, ACCEL ? 44 : 42);
    end
  endtask

  task automatic test_wrap_y();
    obs_t ew, ec;
    // Home, step up past the HUD boundary, then idle so the pulse must drop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, i == 1, 2'b00, 2'b01, i == 0, 1'b0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL wrap_y[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL wrap_y[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
      if (i == 1) begin
        checks += 2;
        if (pos_y_w !== 10'd479 || wrapped_w !== 1'b1) begin
          errors++; $display("[TB] FAIL wrap_y_top: got y=%0d wr=%0d want y=479 wr=1", pos_y_w, wrapped_w);
        end
        if (pos_y_c !== 10'd32 || wrapped_c !== 1'b1 || moving_c !== 1'b0) begin
          errors++; $display("[TB] FAIL clamp_y_top: got y=%0d wr=%0d mov=%0d want y=32 wr=1 mov=0", pos_y_c, wrapped_c, moving_c);
        end
      end
    end
  endtask

  task automatic test_reversal();
    obs_t ew, ec;
    for (int i = 0; i < HOLD + 5; i++) begin
      applyStimulus(1'b1, i != 0, (i < HOLD + 3) ? 2'b10 : 2'b01, 2'b00, i == 0, 1'b0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL reversal[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL reversal[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
    end
    checks++;
    if (pos_x_w !== (ACCEL ? 10'd109 : 10'd108) || speed_w !== 2'd1) begin
      errors++; $display("[TB] FAIL reversal_end: got x=%0d spd=%0d want x=%0d spd=1", pos_x_w, speed_w, ACCEL ? 109 : 108);
    end
  endtask

  task automatic test_freeze_home();
    obs_t ew, ec;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 2'b00, i == 3, 1'b1);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL freeze_home[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL freeze_home[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t ew, ec;
    // Long rightward run crosses the X boundary; clamp instance pins at X_MAX.
    for (int i = 0; i < 621; i++) begin
      applyStimulus(1'b1, i != 0, 2'b10, 2'b00, i == 0, 1'b0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL run_x[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL run_x[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
      if (i == 20) begin
        checks++;
        if (pos_x_w !== (ACCEL ? 10'd132 : 10'd120)) begin
          errors++; $display("[TB] FAIL run_x_20: got %0d want %0d", pos_x_w, ACCEL ? 132 : 120);
        end
      end
    end
    checks++;
    if (pos_x_w !== (ACCEL ? 10'd52 : 10'd80) || pos_x_c !== 10'd639) begin
      errors++; $display("[TB] FAIL run_x_end: got wrap=%0d clamp=%0d want wrap=%0d clamp=639", pos_x_w, pos_x_c, ACCEL ? 52 : 80);
    end
    // Random mix of diagonals, code 11, invalid commands, home, freeze and reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
      ew = sb_w.pop_front(); ec = sb_c.pop_front();
      checks += 2;
      if (obs_w() !== ew) begin errors++; $display("[TB] FAIL random[%0d] wrap: got %s want %s", i, fmt(obs_w()), fmt(ew)); end
      if (obs_c() !== ec) begin errors++; $display("[TB] FAIL random[%0d] clamp: got %s want %s", i, fmt(obs_c()), fmt(ec)); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_accel();
    test_wrap_y();
    test_reversal();
    test_freeze_home();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
